semaphore_sequencer: RTL

Master-side controller for a bank of N semaphore_unit instances. It drives each unit's `en` and `next` inputs and consumes its `red` and `done` outputs. Units get the right of way one at a time, round-robin, with a timed all-red clearance between them. The sequencer paces `next` pulses and faults safely on protocol violations.

---
 rtl/semaphore_pkg.sv | 24 ++
 rtl/tick_timer.sv | 34 +++
 rtl/semaphore_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/semaphore_pkg.sv
// Shared definitions for the semaphore sequencer and the semaphore units it
// drives: sequencer state encoding, index-width helper and the default tick
// constants both sides must agree on.
package semaphore_pkg;

  localparam int unsigned DEF_N_UNITS     = 2;
  localparam int unsigned DEF_STEP_TICKS  = 3;
  localparam int unsigned DEF_CLEAR_TICKS = 4;
  localparam int unsigned DEF_MAX_STEPS   = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CLEAR,
    SEQ_WAIT,
    SEQ_PULSE,
    SEQ_FAULT
  } seq_state_t;

  // Width of a unit index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable up-counter used as the sequencer's phase timer.
// Ports:
//   clk, reset - clock and asynchronous active-low reset
//   clear      - force the count back to zero (wins over inc_en)
//   inc_en     - advance the count this cycle
//   limit      - number of counted cycles in the current phase
//   expired    - high in the cycle that completes the limit-th count
module tick_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc_en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = inc_en && (cnt_q == limit - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (inc_en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/semaphore_sequencer.sv
// Round-robin master for a bank of semaphore units. Grants one unit at a time
// after a timed all-red clearance, paces its advance pulses and latches a
// sticky fault on any protocol violation.
// Ports:
//   clk, reset  - clock and asynchronous active-low reset
//   start       - level; run the sequence (dropping it stops at a unit boundary)
//   hold        - level; freezes the step timer while waiting
//   red, done   - per-unit red lamp state and cycle-complete pulse
//   en, next    - per-unit enable (one-hot or zero) and one-cycle advance pulse
//   active_idx  - index of the granted / next-to-grant unit
//   busy, fault - sequencing in progress / sticky error flag
module semaphore_sequencer import semaphore_pkg::*; #(
  parameter int unsigned N_UNITS     = DEF_N_UNITS,
  parameter int unsigned STEP_TICKS  = DEF_STEP_TICKS,
  parameter int unsigned CLEAR_TICKS = DEF_CLEAR_TICKS,
  parameter int unsigned MAX_STEPS   = DEF_MAX_STEPS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             hold,
  input  logic [N_UNITS-1:0]               red,
  input  logic [N_UNITS-1:0]               done,
  output logic [N_UNITS-1:0]               en,
  output logic [N_UNITS-1:0]               next,
  output logic [idx_width(N_UNITS)-1:0]    active_idx,
  output logic                             busy,
  output logic                             fault
);

  localparam int unsigned IW   = idx_width(N_UNITS);
  localparam int unsigned TMAX = (CLEAR_TICKS > STEP_TICKS) ? CLEAR_TICKS : STEP_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned SW   = $clog2(MAX_STEPS + 1);

  function automatic logic [N_UNITS-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  seq_state_t        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     step_q, step_d;
  logic [N_UNITS-1:0] en_q, en_d, next_q, next_d;
  logic              busy_q, busy_d, fault_q, fault_d;

  logic              timer_clear, timer_inc, timer_expired;
  logic [TW-1:0]     timer_limit;
  logic              done_own, done_stray;
  logic [SW-1:0]     step_inc;
  logic [IW-1:0]     idx_wrap;

  // CLEAR and WAIT never overlap, so one timer serves both; it restarts on
  // every state change.
  assign timer_clear = (state_d != state_q);
  assign timer_inc   = (state_q == SEQ_CLEAR) || ((state_q == SEQ_WAIT) && !hold);
  assign timer_limit = (state_q == SEQ_CLEAR) ? TW'(CLEAR_TICKS) : TW'(STEP_TICKS);

  tick_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .inc_en  (timer_inc),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  assign done_own   = done[idx_q];
  assign done_stray = |(done & ~onehot(idx_q));
  assign step_inc   = step_q + SW'(1);
  assign idx_wrap   = (idx_q == IW'(N_UNITS - 1)) ? '0 : idx_q + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      en_q    <= '0;
      next_q  <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      en_q    <= en_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (|done)      state_d = SEQ_FAULT;
        else if (start) state_d = SEQ_CLEAR;
      end
      SEQ_CLEAR: begin
        if (|done) state_d = SEQ_FAULT;
        else if (timer_expired) begin
          if (&red) begin
            state_d = SEQ_WAIT;
            step_d  = '0;
          end else begin
            state_d = SEQ_FAULT;
          end
        end
      end
      SEQ_WAIT, SEQ_PULSE: begin
        if (done_stray) begin
          state_d = SEQ_FAULT;
        end else if (done_own) begin
          // Completion outranks the step watchdog firing in the same cycle.
          idx_d   = idx_wrap;
          state_d = start ? SEQ_CLEAR : SEQ_IDLE;
        end else if (state_q == SEQ_WAIT) begin
          if (timer_expired) state_d = SEQ_PULSE;
        end else begin
          step_d  = step_inc;
          state_d = (step_inc == SW'(MAX_STEPS)) ? SEQ_FAULT : SEQ_WAIT;
        end
      end
      default: state_d = SEQ_FAULT;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register.
  always_comb begin
    en_d    = '0;
    next_d  = '0;
    busy_d  = (state_d != SEQ_IDLE) && (state_d != SEQ_FAULT);
    fault_d = (state_d == SEQ_FAULT);
    if ((state_d == SEQ_WAIT) || (state_d == SEQ_PULSE)) en_d   = onehot(idx_d);
    if (state_d == SEQ_PULSE)                            next_d = onehot(idx_d);
  end

  assign en         = en_q;
  assign next       = next_q;
  assign active_idx = idx_q;
  assign busy       = busy_q;
  assign fault      = fault_q;

endmodule
